if_prefetch_buffer: RTL and testbench

// - Instruction prefetch queue between instruction memory and the IF/ID pipeline register.
// - Issues in-order fetch requests to a variable-latency memory, buffers returned words tagged with their PC,
//   and hands {pc, instr} to the IF stage under a valid/ready handshake.
// - Flushes on a branch/jump redirect, discarding in-flight responses, so the core can stall (hazard) without re-fetching.

---
 rtl/if_prefetch_buffer_pkg.sv | 13 +
 rtl/if_prefetch_buffer_fifo.sv | 44 ++++
 rtl/if_prefetch_buffer.sv | 104 ++++++++++
 tb/tb_if_prefetch_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_buffer_pkg.sv
// rtl/if_prefetch_buffer_pkg.sv - shared types and constants for the instruction prefetch buffer
package if_pf_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {IDLE, RUN} pf_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } pf_entry_t;
endpackage

// File: rtl/if_prefetch_buffer_fifo.sv
// rtl/if_prefetch_buffer_fifo.sv - DEPTH-entry FIFO of {pc, instr}; clear wins over push
module pf_fifo
  import if_pf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  pf_entry_t     din,
  output pf_entry_t     head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  pf_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/if_prefetch_buffer.sv
// rtl/if_prefetch_buffer.sv - in-order instruction prefetch queue with redirect flush
// Optional PF_BYPASS_EN: a response arriving at an empty queue with ready high is forwarded the same cycle.
module if_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = if_pf_pkg::ADDR_W,
  parameter int DATA_W = if_pf_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o
);
  import if_pf_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  pf_state_e         state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redir_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     out_next;
  pf_entry_t         head;
  pf_entry_t         push_entry;
  logic              ack, rsp, redir, keep, push, pop, empty, bypass;

  // Credit: buffered plus in-flight words never exceed the queue size.
  assign mem_req_o  = (state == RUN) &&
                      (({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));
  assign mem_addr_o = fetch_pc;

  assign ack      = mem_req_o && mem_ack_i;
  assign rsp      = mem_rvalid_i && (outstanding != '0);
  assign redir    = (state == RUN) && redirect_i;
  assign keep     = rsp && (drop_cnt == '0) && !redir;
  assign empty    = (count == '0);
  assign out_next = outstanding + CW'(ack) - CW'(rsp);
  assign redir_pc = redirect_pc_i & ~ADDR_W'(3);

`ifdef PF_BYPASS_EN
  assign bypass        = keep && empty && instr_ready_i;
  assign instr_valid_o = !empty || bypass;
  assign instr_o       = bypass ? mem_rdata_i : head.instr;
  assign pc_o          = bypass ? resp_pc : head.pc;
`else
  assign bypass        = 1'b0;
  assign instr_valid_o = !empty;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;
`endif

  assign push             = keep && !bypass;
  assign pop              = !empty && instr_ready_i;
  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = mem_rdata_i;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (redir),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (state == IDLE && start_i) state <= RUN;
      if (redir) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
        drop_cnt <= out_next;
      end else begin
        if (ack)  fetch_pc <= fetch_pc + STEP;
        if (keep) resp_pc  <= resp_pc + STEP;
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb/tb_if_prefetch_buffer.sv - randomized scoreboard bench for if_prefetch_buffer
module tb_if_prefetch_buffer;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  if_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; bit live; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  req_t infl[$];
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int p_ack = 0, p_rv = 0, p_rdy = 0, p_redir = 0;
  bit go = 0, stale_rv = 0, force_redir = 0, watch = 0, running = 0;
  logic [31:0] force_pc = '0, m_fetch = '0, first_pc = '0;
  int ack_cnt = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver and reference model: memory side plus expected delivery queue.
  initial begin
    logic ack, redir;
    req_t r;
    forever begin
      @(negedge clk_i);
      start_i       = go;
      instr_ready_i = ($urandom_range(99) < p_rdy);
      mem_ack_i     = ($urandom_range(99) < p_ack);
      if (infl.size() > 0) begin
        mem_rvalid_i = ($urandom_range(99) < p_rv);
        mem_rdata_i  = mem_word(infl[0].addr);
      end else begin
        mem_rvalid_i = stale_rv;
        mem_rdata_i  = $urandom;
      end
      if (force_redir) begin
        redirect_i    = 1'b1;
        redirect_pc_i = force_pc;
        force_redir   = 0;
      end else begin
        redirect_i    = ($urandom_range(99) < p_redir);
        redirect_pc_i = $urandom;
      end
      #1;
      if (rst_i) begin
        chk("req", mem_req_o, running && (exp_q.size() + infl.size() < DEPTH));
`ifndef PF_BYPASS_EN
        chk("valid", instr_valid_o, exp_q.size() > 0);
`endif
        ack   = mem_req_o && mem_ack_i;
        redir = running && redirect_i;
        if (ack) begin
          chk("addr", mem_addr_o, m_fetch);
          ack_cnt++;
        end
        if (mem_rvalid_i && infl.size() > 0) begin
          r = infl.pop_front();
          if (r.live && !redir) exp_q.push_back('{r.addr, mem_word(r.addr)});
        end
        if (ack) begin
          infl.push_back('{m_fetch, 1'b1});
          m_fetch += 4;
        end
        if (redir) begin
          foreach (infl[i]) infl[i].live = 0;
          m_fetch = redirect_pc_i & ~32'h3;
        end
        if (start_i) running = 1;
        #2;
        if (redir) exp_q.delete();
      end
    end
  end

  // Monitor: compares each accepted instruction against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i && instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", instr_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("pc", pc_o, e.pc);
          chk("instr", instr_o, e.instr);
          if (watch) begin
            first_pc = pc_o;
            watch = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  task automatic run(int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic knobs(int a, int v, int r, int d);
    p_ack = a; p_rv = v; p_rdy = r; p_redir = d;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #5;
    rst_i = 0; go = 0; start_i = 0;
    exp_q.delete(); infl.delete();
    running = 0; m_fetch = 32'h0;
    #1;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    @(negedge clk_i);
    #5;
    rst_i = 1;
  endtask

  initial begin
    do_reset();
    // Idle: no requests, redirects ignored.
    knobs(100, 100, 100, 50);
    run(6);
    // Stall from start: exactly DEPTH requests, then in-order drain.
    knobs(100, 100, 0, 0);
    ack_cnt = 0;
    go = 1;
    run(14);
    chk("stall_acks", ack_cnt, DEPTH);
    knobs(100, 100, 100, 0);
    run(20);
    // Redirect to 0x103 with two requests outstanding.
    knobs(0, 100, 100, 0);
    run(8);
    knobs(100, 0, 100, 0);
    run(2);
    knobs(0, 0, 100, 0);
    force_pc = 32'h103; force_redir = 1; watch = 1;
    run(1);
    knobs(100, 100, 100, 0);
    run(16);
    chk("redir_first_pc", first_pc, 32'h100);
    // Redirect, response and pop in the same cycle.
    knobs(0, 100, 100, 0);
    run(8);
    knobs(100, 0, 0, 0);
    run(2);
    knobs(0, 100, 0, 0);
    run(1);
    knobs(0, 100, 100, 0);
    force_pc = 32'h2000; force_redir = 1;
    run(1);
    knobs(100, 100, 100, 0);
    run(12);
    // Random traffic.
    for (int k = 0; k < 12; k++) begin
      knobs($urandom_range(30, 100), $urandom_range(30, 100),
            $urandom_range(0, 100), $urandom_range(0, 8));
      run(50);
    end
    // Reset mid-burst, then stale responses.
    knobs(0, 100, 100, 0);
    run(8);
    knobs(100, 0, 0, 0);
    run(3);
    do_reset();
    stale_rv = 1;
    knobs(100, 100, 100, 0);
    run(4);
    go = 1;
    run(20);
    stale_rv = 0;
    knobs(0, 100, 100, 0);
    run(10);
    chk("final_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
